// File: rtl/pc_fetch_if.sv
// pc_fetch_if: fetch-address handshake between the PC sequencer and instruction memory
interface pc_fetch_if #(parameter int AW = 32);
    logic          if_req;
    logic          if_ready;
    logic [AW-1:0] pc;
    logic [AW-1:0] pc_plus4;
    modport master (output if_req, pc, pc_plus4, input if_ready);
    modport slave  (input if_req, pc, pc_plus4, output if_ready);
endinterface

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: fetch PC register and next-PC sequencer with one-instruction delay slot
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          AW       = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    pc_fetch_if.master    fif,
    input  logic          d_valid,
    input  logic [AW-1:0] d_pc,
    input  logic [1:0]    d_kind,
    input  logic          jump,
    input  logic [15:0]   d_imm16,
    input  logic [25:0]   d_idx26,
    input  logic [AW-1:0] jr_addr,
    output logic [AW-1:0] link_addr,
    output logic          redir_pend,
    output logic          slot_err
);
    typedef enum logic {RUN, PEND} state_t;
    state_t        state, state_nxt;
    logic [AW-1:0] pc, pend_tgt, target, pc_nxt, d_pc4, br_tgt, j_tgt;
    logic          req, acc, dc, tk, ld_pend;

    // A stalled cycle can neither accept a fetch nor consume the D-stage instruction
    assign acc       = req & fif.if_ready & ~stall;
    assign dc        = d_valid & ~stall;
    assign tk        = dc & (d_kind == 2'd1 ? jump : d_kind != 2'd0);
    assign d_pc4     = d_pc + 32'd4;
    assign link_addr = d_pc + 32'd8;
    assign br_tgt    = d_pc4 + {{14{d_imm16[15]}}, d_imm16, 2'b00};
    assign j_tgt     = {d_pc4[AW-1:AW-4], d_idx26, 2'b00};
    assign target    = d_kind == 2'd1 ? br_tgt : d_kind == 2'd2 ? j_tgt : jr_addr;

    assign fif.if_req   = req;
    assign fif.pc       = pc;
    assign fif.pc_plus4 = pc + 32'd4;

    // State register: RUN, or PEND while a redirect waits for its delay-slot fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    // Next state: a redirect that misses the accept parks in PEND until the next accept
    always_comb begin
        state_nxt = state == RUN ? ((tk & ~acc) ? PEND : RUN) : (acc ? RUN : PEND);
    end

    // Outputs: pending target wins, then a fresh redirect, else sequential
    always_comb begin
        redir_pend = state == PEND;
        ld_pend    = (state == RUN) & tk & ~acc;
        pc_nxt     = state == PEND ? pend_tgt : tk ? target : pc + 32'd4;
    end

    // Datapath registers; a redirect seen while PEND is dropped but flagged sticky
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            req      <= 1'b0;
            pend_tgt <= '0;
            slot_err <= 1'b0;
        end else begin
            req      <= 1'b1;
            if (acc) pc <= pc_nxt;
            if (ld_pend) pend_tgt <= target;
            slot_err <= slot_err | (redir_pend & tk);
        end
    end
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: table-driven directed bench for the fetch PC sequencer
module tb_pc_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, stall, d_valid, jump;
    logic [31:0] d_pc, jr_addr, link_addr;
    logic [1:0]  d_kind;
    logic [15:0] d_imm16;
    logic [25:0] d_idx26;
    logic        redir_pend, slot_err;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    pc_fetch_if fif();

    pc_fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .fif(fif),
        .d_valid(d_valid), .d_pc(d_pc), .d_kind(d_kind), .jump(jump),
        .d_imm16(d_imm16), .d_idx26(d_idx26), .jr_addr(jr_addr),
        .link_addr(link_addr), .redir_pend(redir_pend), .slot_err(slot_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall, rdy, dv;
        logic [31:0] dpc;
        logic [1:0]  kind;
        logic        jump;
        logic [15:0] imm;
        logic [25:0] idx;
        logic [31:0] jr, e_pc;
        logic        e_req, e_pend, e_serr;
        logic [31:0] e_link;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(logic s, logic r, logic dv, logic [31:0] dpc, logic [1:0] k,
                                logic j, logic [15:0] imm, logic [25:0] idx, logic [31:0] jr,
                                logic [31:0] e_pc, logic e_req, logic e_pend, logic e_serr,
                                logic [31:0] e_link);
        vec_t v;
        v.stall = s; v.rdy = r; v.dv = dv; v.dpc = dpc; v.kind = k; v.jump = j;
        v.imm = imm; v.idx = idx; v.jr = jr; v.e_pc = e_pc; v.e_req = e_req;
        v.e_pend = e_pend; v.e_serr = e_serr; v.e_link = e_link;
        return v;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", n, act, exp);
    endtask

    // Drive one vector at the falling edge, check after the rising edge, return at the next falling edge
    task automatic apply(input string tag, input vec_t v);
        stall = v.stall; fif.if_ready = v.rdy; d_valid = v.dv; d_pc = v.dpc; d_kind = v.kind;
        jump = v.jump; d_imm16 = v.imm; d_idx26 = v.idx; jr_addr = v.jr;
        @(posedge clk);
        #1;
        chk({tag, ".pc"}, fif.pc, v.e_pc);
        chk({tag, ".pc_plus4"}, fif.pc_plus4, v.e_pc + 32'd4);
        chk({tag, ".if_req"}, {31'd0, fif.if_req}, {31'd0, v.e_req});
        chk({tag, ".redir_pend"}, {31'd0, redir_pend}, {31'd0, v.e_pend});
        chk({tag, ".slot_err"}, {31'd0, slot_err}, {31'd0, v.e_serr});
        chk({tag, ".link_addr"}, link_addr, v.e_link);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; fif.if_ready = 1'b0; d_valid = 1'b0; d_pc = '0;
        d_kind = '0; jump = 1'b0; d_imm16 = '0; d_idx26 = '0; jr_addr = '0;
        //               st rdy dv dpc            k  j  imm       idx          jr             e_pc           req pend serr link
        vecs[0]  = mk(0, 1, 0, 32'h0,        0, 0, 16'h0,    26'h0,       32'h0,         32'h0000_3000, 1, 0, 0, 32'h0000_0008);
        vecs[1]  = mk(0, 1, 0, 32'h0,        0, 0, 16'h0,    26'h0,       32'h0,         32'h0000_3004, 1, 0, 0, 32'h0000_0008);
        vecs[2]  = mk(0, 1, 1, 32'h3000,     0, 0, 16'h0,    26'h0,       32'h0,         32'h0000_3008, 1, 0, 0, 32'h0000_3008);
        vecs[3]  = mk(0, 1, 1, 32'h3004,     1, 1, 16'h0004, 26'h0,       32'h0,         32'h0000_3018, 1, 0, 0, 32'h0000_300C);
        vecs[4]  = mk(0, 1, 1, 32'h3008,     0, 0, 16'h0,    26'h0,       32'h0,         32'h0000_301C, 1, 0, 0, 32'h0000_3010);
        vecs[5]  = mk(0, 1, 1, 32'h3018,     1, 0, 16'h0004, 26'h0,       32'h0,         32'h0000_3020, 1, 0, 0, 32'h0000_3020);
        vecs[6]  = mk(0, 1, 1, 32'h301C,     0, 0, 16'h0,    26'h0,       32'h0,         32'h0000_3024, 1, 0, 0, 32'h0000_3024);
        vecs[7]  = mk(0, 0, 1, 32'h3020,     3, 0, 16'h0,    26'h0,       32'h0000_4000, 32'h0000_3024, 1, 1, 0, 32'h0000_3028);
        vecs[8]  = mk(0, 0, 0, 32'h0,        0, 0, 16'h0,    26'h0,       32'h0,         32'h0000_3024, 1, 1, 0, 32'h0000_0008);
        vecs[9]  = mk(0, 0, 0, 32'h0,        0, 0, 16'h0,    26'h0,       32'h0,         32'h0000_3024, 1, 1, 0, 32'h0000_0008);
        vecs[10] = mk(0, 1, 0, 32'h0,        0, 0, 16'h0,    26'h0,       32'h0,         32'h0000_4000, 1, 0, 0, 32'h0000_0008);
        vecs[11] = mk(0, 1, 0, 32'h0,        0, 0, 16'h0,    26'h0,       32'h0,         32'h0000_4004, 1, 0, 0, 32'h0000_0008);
        vecs[12] = mk(0, 1, 1, 32'h3010,     2, 0, 16'h0,    26'h0000C40, 32'h0,         32'h0000_3100, 1, 0, 0, 32'h0000_3018);
        vecs[13] = mk(1, 1, 1, 32'h3010,     2, 0, 16'h0,    26'h0000C40, 32'h0,         32'h0000_3100, 1, 0, 0, 32'h0000_3018);
        vecs[14] = mk(0, 1, 0, 32'h0,        0, 0, 16'h0,    26'h0,       32'h0,         32'h0000_3104, 1, 0, 0, 32'h0000_0008);
        vecs[15] = mk(0, 1, 1, 32'h3104,     1, 1, 16'hFFFE, 26'h0,       32'h0,         32'h0000_3100, 1, 0, 0, 32'h0000_310C);
        vecs[16] = mk(0, 1, 1, 32'h0,        3, 0, 16'h0,    26'h0,       32'h0000_5003, 32'h0000_5003, 1, 0, 0, 32'h0000_0008);
        vecs[17] = mk(0, 1, 1, 32'hFFFF_FFF8, 1, 1, 16'h0002, 26'h0,      32'h0,         32'h0000_0004, 1, 0, 0, 32'h0000_0000);
        vecs[18] = mk(0, 1, 1, 32'hA000_0000, 2, 0, 16'h0,   26'h3FFFFFF, 32'h0,         32'hAFFF_FFFC, 1, 0, 0, 32'hA000_0008);

        repeat (2) @(posedge clk);
        #1;
        chk("rst.pc", fif.pc, 32'h0000_3000);
        chk("rst.if_req", {31'd0, fif.if_req}, 32'd0);
        chk("rst.redir_pend", {31'd0, redir_pend}, 32'd0);
        chk("rst.slot_err", {31'd0, slot_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 19; i++) apply($sformatf("v%0d", i), vecs[i]);

        apply("h1", mk(0, 0, 1, 32'h0, 3, 0, 16'h0, 26'h0, 32'h0000_6000, 32'hAFFF_FFFC, 1, 1, 0, 32'h8));
        apply("h2", mk(0, 0, 1, 32'h0, 3, 0, 16'h0, 26'h0, 32'h0000_7000, 32'hAFFF_FFFC, 1, 1, 1, 32'h8));
        apply("h3", mk(1, 1, 1, 32'h0, 3, 0, 16'h0, 26'h0, 32'h0000_7000, 32'hAFFF_FFFC, 1, 1, 1, 32'h8));
        apply("h4", mk(0, 1, 0, 32'h0, 0, 0, 16'h0, 26'h0, 32'h0,         32'h0000_6000, 1, 0, 1, 32'h8));
        apply("h5", mk(0, 0, 1, 32'h0, 3, 0, 16'h0, 26'h0, 32'h0000_8000, 32'h0000_6000, 1, 1, 1, 32'h8));

        rst_n = 1'b0;
        #1;
        chk("arst.pc", fif.pc, 32'h0000_3000);
        chk("arst.if_req", {31'd0, fif.if_req}, 32'd0);
        chk("arst.redir_pend", {31'd0, redir_pend}, 32'd0);
        chk("arst.slot_err", {31'd0, slot_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        apply("r0", mk(0, 1, 0, 32'h0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h0000_3000, 1, 0, 0, 32'h8));
        apply("r1", mk(0, 1, 0, 32'h0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h0000_3004, 1, 0, 0, 32'h8));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
